// File: rtl/wishbone_pkg.sv
// wishbone_pkg: shared definitions for the Wishbone master port.
// Holds the FSM state encodings and the 2-bit response status codes.
// There are no ports; the other files pull this in with import wishbone_pkg::*.
package wishbone_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BACKOFF = 2'd2
    } wb_state_e;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ERR     = 2'b01;
    localparam logic [1:0] STATUS_RETRY   = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

endpackage

// File: rtl/wb_sat_counter.sv
// wb_sat_counter: up-counter that saturates at all-ones and never wraps.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset, clears count
//   clr   - synchronous clear, takes priority over en
//   en    - count enable
//   count - current count value (WIDTH bits)
module wb_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding Wishbone master with retry/backoff.
// A local request is captured in IDLE, presented on the bus in ACTIVE until
// err_i/ack_i/rty_i (priority in that order), and answered with a one-cycle
// rsp_valid_o pulse carrying read data and a 2-bit status.
// Optional feature: define WB_MASTER_TIMEOUT_EN to terminate an ACTIVE phase
// after TIMEOUT_CYCLES cycles with status 11.
// Ports:
//   clk, reset                  - clock and async active-high reset
//   req_* inputs                - local request (valid, we, addr, data, sel, tag)
//   req_ready_o                 - high only in IDLE
//   rsp_valid_o/data_o/status_o - response pulse, read data, status
//   adr_o..cyc_o                - Wishbone master outputs
//   dat_i, ack_i, err_i, rty_i  - Wishbone slave responses
//
// state   | meaning
// IDLE    | ready for a local request
// ACTIVE  | cyc_o/stb_o asserted, waiting for a termination
// BACKOFF | bus released after rty_i, counting down before re-issue
module wb_master_port
    import wishbone_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEL_WIDTH      = 4,
    parameter int TAG_WIDTH      = 3,
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [SEL_WIDTH-1:0]  req_sel_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [1:0]            rsp_status_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  we_o,
    output logic                  stb_o,
    output logic                  cyc_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  rty_i
);

    localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [3:0] BO_LAST   = 4'(BACKOFF_CYCLES - 1);

    wb_state_e             state_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  we_q;
    logic                  cyc_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [1:0]            rsp_status_q;

    logic [7:0] retry_cnt;
    logic [3:0] bo_cnt;

    logic accept, in_active, in_backoff;
    logic term_err, term_ack, term_rty, term_to;
    logic rty_again, rty_final, backoff_done;

    assign accept       = (state_q == IDLE) && req_i;
    assign in_active    = (state_q == ACTIVE);
    assign in_backoff   = (state_q == BACKOFF);
    assign term_err     = in_active && err_i;
    assign term_ack     = in_active && !err_i && ack_i;
    assign term_rty     = in_active && !err_i && !ack_i && rty_i;
    assign rty_again    = term_rty && (retry_cnt < RETRY_MAX);
    assign rty_final    = term_rty && (retry_cnt >= RETRY_MAX);
    assign backoff_done = in_backoff && (bo_cnt == BO_LAST);

    wb_sat_counter #(.WIDTH(8)) u_retry_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (rty_again),
        .count (retry_cnt)
    );

    // Cleared on the rty_i that starts the backoff, so each backoff
    // interval lasts exactly BACKOFF_CYCLES cycles.
    wb_sat_counter #(.WIDTH(4)) u_backoff_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (rty_again),
        .en    (in_backoff),
        .count (bo_cnt)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;

    // Cleared on every entry into ACTIVE; fires in the last allowed
    // ACTIVE cycle unless a real termination arrives in that cycle.
    wb_sat_counter #(.WIDTH(16)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept || backoff_done),
        .en    (in_active),
        .count (to_cnt)
    );

    assign term_to = in_active && !err_i && !ack_i && !rty_i && (to_cnt == TO_LAST);
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
    assign term_to = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            tag_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= STATUS_OK;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        adr_q   <= req_addr_i;
                        dat_q   <= req_data_i;
                        sel_q   <= req_sel_i;
                        tag_q   <= req_tag_i;
                        we_q    <= req_we_i;
                        cyc_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (term_err || term_ack || rty_final || term_to) begin
                        state_q     <= IDLE;
                        cyc_q       <= 1'b0;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= (term_ack && !we_q) ? dat_i : '0;
                        if (term_err)      rsp_status_q <= STATUS_ERR;
                        else if (term_ack) rsp_status_q <= STATUS_OK;
                        else if (term_rty) rsp_status_q <= STATUS_RETRY;
                        else               rsp_status_q <= STATUS_TIMEOUT;
                    end else if (rty_again) begin
                        state_q <= BACKOFF;
                        cyc_q   <= 1'b0;
                    end
                end
                BACKOFF: begin
                    if (backoff_done) begin
                        state_q <= ACTIVE;
                        cyc_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;
    assign sel_o        = sel_q;
    assign tag_o        = tag_q;
    assign we_o         = we_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;

endmodule

// File: tb/tb_wb_master_port.sv
// tb_wb_master_port: self-checking bench for wb_master_port.
// The bench plays the Wishbone slave from a per-transaction script of
// (wait states, termination) attempts and checks the response against
// expectations from a vector table and from a transaction-level model.
module tb_wb_master_port;
    localparam int MR = 2;
    localparam int BO = 2;
    localparam int TO = 8;

    // termination codes used by the slave script
    localparam int T_ACK = 0, T_ERR = 1, T_RTY = 2, T_NONE = 3, T_ALL = 4, T_ACKRTY = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i, req_we_i;
    logic [31:0] req_addr_i, req_data_i;
    logic [3:0]  req_sel_i;
    logic [2:0]  req_tag_i;
    logic        req_ready_o, rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_status_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [2:0]  tag_o;
    logic        we_o, stb_o, cyc_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, rty_i;

    always #5 clk = ~clk;

    wb_master_port #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SEL_WIDTH(4), .TAG_WIDTH(3),
        .MAX_RETRY(MR), .BACKOFF_CYCLES(BO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_sel_i(req_sel_i), .req_tag_i(req_tag_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .tag_o(tag_o),
        .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slave script for the current transaction
    int scr_n;
    int scr_w[3];
    int scr_t[3];

    // observations of the current transaction
    int          obs_k, obs_cyc, obs_field_err, obs_gap_err;
    logic        obs_got;
    logic [1:0]  obs_status;
    logic [31:0] obs_data;
    logic        obs_ready, obs_cyc_at_rsp;

    task automatic tick();
        if (cyc_o === 1'b1) obs_cyc++;
        @(posedge clk);
        #1;
        obs_k++;
    endtask

    // Presents a request in the current cycle, plays the slave script,
    // and returns at the cycle in which the response is visible.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [3:0] sel, input logic [2:0] tag);
        int guard;
        obs_k = 0; obs_cyc = 0; obs_field_err = 0; obs_gap_err = 0;
        req_i = 1'b1; req_we_i = we; req_addr_i = addr; req_data_i = wdata;
        req_sel_i = sel; req_tag_i = tag;
        tick();
        req_i = 1'b0; req_addr_i = ~addr; req_data_i = ~wdata; req_sel_i = ~sel;
        req_tag_i = ~tag; req_we_i = ~we;
        if (rsp_valid_o !== 1'b0) obs_field_err++;
        for (int a = 0; a < scr_n; a++) begin
            for (int w = 0; w <= scr_w[a]; w++) begin
                if (!(cyc_o === 1'b1 && stb_o === 1'b1 && adr_o === addr && dat_o === wdata &&
                      sel_o === sel && tag_o === tag && we_o === we))
                    obs_field_err++;
                dat_i = $urandom;
                if (w == scr_w[a]) begin
                    ack_i = (scr_t[a] == T_ACK) || (scr_t[a] == T_ALL) || (scr_t[a] == T_ACKRTY);
                    err_i = (scr_t[a] == T_ERR) || (scr_t[a] == T_ALL);
                    rty_i = (scr_t[a] == T_RTY) || (scr_t[a] == T_ALL) || (scr_t[a] == T_ACKRTY);
                    if (ack_i) dat_i = rdata;
                end
                tick();
                ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
            end
            if (a < scr_n - 1) begin
                for (int b = 0; b < BO; b++) begin
                    if (cyc_o !== 1'b0 || stb_o !== 1'b0) obs_gap_err++;
                    tick();
                end
            end
        end
        guard = 0;
        while (rsp_valid_o !== 1'b1 && guard < 64) begin
            tick();
            guard++;
        end
        obs_got = rsp_valid_o;
        obs_status = rsp_status_o;
        obs_data = rsp_data_o;
        obs_ready = req_ready_o;
        obs_cyc_at_rsp = cyc_o;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic [2:0]  tag;
        int          n;
        int          w0, w1, w2;
        int          t0, t1, t2;
        logic [1:0]  st;
        logic [31:0] data;
        int          lat;
        int          cyc;
    } vec_t;

    vec_t vecs[10];
    int   n_vec;

    task automatic check_rsp(input string pfx, input logic [1:0] st, input logic [31:0] data,
                             input int lat);
        check({pfx, "_valid"}, 64'(obs_got), 64'(1));
        check({pfx, "_status"}, 64'(obs_status), 64'(st));
        check({pfx, "_data"}, 64'(obs_data), 64'(data));
        check({pfx, "_latency"}, 64'(obs_k), 64'(lat));
        check({pfx, "_ready"}, 64'({obs_ready, obs_cyc_at_rsp}), 64'(2'b10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b1;
        req_i = 0; req_we_i = 0; req_addr_i = 0; req_data_i = 0; req_sel_i = 0; req_tag_i = 0;
        dat_i = 0; ack_i = 0; err_i = 0; rty_i = 0;
        scr_n = 1; scr_w[0] = 0; scr_w[1] = 0; scr_w[2] = 0;
        scr_t[0] = T_ACK; scr_t[1] = T_ACK; scr_t[2] = T_ACK;

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_ctrl", 64'({req_ready_o, rsp_valid_o, cyc_o, stb_o, we_o}), 64'(5'b10000));
        check("reset_rsp", 64'({rsp_status_o, rsp_data_o}), 64'(0));
        check("reset_bus", 64'({adr_o, dat_o, sel_o, tag_o}), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // {we, addr, wdata, rdata, sel, tag, n, w0..w2, t0..t2, status, data, latency, cyc}
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 4'hF, 3'd1, 1, 0, 0, 0,
                    T_ACK, 0, 0, 2'b00, 32'hDEAD_BEEF, 2, 1};
        vecs[1] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h1111_2222, 4'h3, 3'd2, 1, 3, 0, 0,
                    T_ERR, 0, 0, 2'b01, 32'h0, 5, 4};
        vecs[2] = '{1'b0, 32'h0000_0080, 32'h0, 32'h3333_4444, 4'hF, 3'd3, 3, 0, 0, 0,
                    T_RTY, T_RTY, T_RTY, 2'b10, 32'h0, 8, 3};
        vecs[3] = '{1'b1, 32'h1234_0000, 32'h0BAD_CAFE, 32'h5555_6666, 4'h8, 3'd4, 1, 1, 0, 0,
                    T_ACK, 0, 0, 2'b00, 32'h0, 3, 2};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 4'hF, 3'd5, 3, 1, 0, 2,
                    T_RTY, T_RTY, T_ACK, 2'b00, 32'h1234_5678, 11, 6};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0, 32'h7777_8888, 4'h1, 3'd6, 2, 0, 2, 0,
                    T_RTY, T_ERR, 0, 2'b01, 32'h0, 7, 4};
        vecs[6] = '{1'b0, 32'h0000_0200, 32'h0, 32'hAAAA_5555, 4'hF, 3'd7, 1, 0, 0, 0,
                    T_ALL, 0, 0, 2'b01, 32'h0, 2, 1};
        vecs[7] = '{1'b0, 32'h0000_0300, 32'h0, 32'h0F0F_0F0F, 4'hF, 3'd0, 1, 0, 0, 0,
                    T_ACKRTY, 0, 0, 2'b00, 32'h0F0F_0F0F, 2, 1};
`ifdef WB_MASTER_TIMEOUT_EN
        vecs[8] = '{1'b0, 32'h0000_0400, 32'h0, 32'h0, 4'hF, 3'd1, 1, 7, 0, 0,
                    T_NONE, 0, 0, 2'b11, 32'h0, 9, 8};
        vecs[9] = '{1'b0, 32'h0000_0500, 32'h0, 32'h0000_0055, 4'hF, 3'd2, 1, 7, 0, 0,
                    T_ACK, 0, 0, 2'b00, 32'h0000_0055, 9, 8};
        n_vec = 10;
`else
        vecs[8] = '{1'b0, 32'h0000_0400, 32'h0, 32'h9999_0000, 4'hF, 3'd1, 1, 40, 0, 0,
                    T_ACK, 0, 0, 2'b00, 32'h9999_0000, 42, 41};
        n_vec = 9;
`endif

        // vectors run back to back: each request is presented in the
        // cycle the previous response pulses
        for (int i = 0; i < n_vec; i++) begin
            scr_n = vecs[i].n;
            scr_w[0] = vecs[i].w0; scr_w[1] = vecs[i].w1; scr_w[2] = vecs[i].w2;
            scr_t[0] = vecs[i].t0; scr_t[1] = vecs[i].t1; scr_t[2] = vecs[i].t2;
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].sel, vecs[i].tag);
            check_rsp($sformatf("vec%0d", i), vecs[i].st, vecs[i].data, vecs[i].lat);
            check($sformatf("vec%0d_cyc_cycles", i), 64'(obs_cyc), 64'(vecs[i].cyc));
            check($sformatf("vec%0d_bus_fields", i), 64'(obs_field_err), 64'(0));
            check($sformatf("vec%0d_backoff_gap", i), 64'(obs_gap_err), 64'(0));
        end

        tick();
        check("rsp_pulse_width", 64'(rsp_valid_o), 64'(0));

        // reset in the second ACTIVE cycle
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0000_0600; req_data_i = 32'h0;
        req_sel_i = 4'hF; req_tag_i = 3'd3;
        tick();
        req_i = 1'b0;
        tick();
        check("rst_mid_pre_cyc", 64'(cyc_o), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_async", 64'({cyc_o, stb_o, req_ready_o}), 64'(3'b001));
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid_o !== 1'b0 || cyc_o !== 1'b0 || req_ready_o !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_rsp", 64'(bad), 64'(0));
        scr_n = 1; scr_w[0] = 0; scr_t[0] = T_ACK;
        do_txn(1'b0, 32'h0000_0700, 32'h0, 32'hC0DE_0001, 4'hF, 3'd2);
        check_rsp("rst_mid_next", 2'b00, 32'hC0DE_0001, 2);

        // randomized transactions against the transaction-level model
        for (int i = 0; i < 25; i++) begin
            logic        we;
            logic [31:0] addr, wdata, rdata;
            logic [3:0]  sel;
            logic [2:0]  tag;
            logic [1:0]  exp_st;
            logic [31:0] exp_data;
            int          exp_lat, exp_cyc;
            we = 1'($urandom_range(0, 1));
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            sel = 4'($urandom); tag = 3'($urandom);
            // attempts continue while the slave asks for a retry and
            // re-issues remain; MR retries means at most MR+1 attempts
            scr_n = 0;
            do begin
                scr_w[scr_n] = $urandom_range(0, 3);
                scr_t[scr_n] = $urandom_range(0, 2);
                scr_n++;
            end while (scr_t[scr_n-1] == T_RTY && scr_n < MR + 1);
            exp_cyc = 0;
            for (int a = 0; a < scr_n; a++) exp_cyc += scr_w[a] + 1;
            exp_lat = 1 + exp_cyc + BO * (scr_n - 1);
            case (scr_t[scr_n-1])
                T_ACK:   exp_st = 2'b00;
                T_ERR:   exp_st = 2'b01;
                default: exp_st = 2'b10;
            endcase
            exp_data = (scr_t[scr_n-1] == T_ACK && !we) ? rdata : 32'h0;
            do_txn(we, addr, wdata, rdata, sel, tag);
            check_rsp($sformatf("rnd%0d", i), exp_st, exp_data, exp_lat);
            check($sformatf("rnd%0d_bus", i), 64'({obs_field_err, obs_gap_err}), 64'(0));
            check($sformatf("rnd%0d_cyc_cycles", i), 64'(obs_cyc), 64'(exp_cyc));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_master_port.md
WB_MASTER_PORT -- requirements
Module: wb_master_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data width of the Wishbone bus and the local port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter SEL_WIDTH, default 4, byte-select width.
REQ-004 SHALL have parameter TAG_WIDTH, default 3, merged {tga,tgb,tgc} tag width.
REQ-005 SHALL have parameter MAX_RETRY, default 3, range 0..255, number of re-issues allowed after rty_i.
REQ-006 SHALL have parameter BACKOFF_CYCLES, default 2, range 1..15, cycles cyc_o is held low between retries.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, cycles the port waits for a termination.
REQ-008 SHALL have port clk, input, 1, clock; all logic is on the rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have local request ports req_i (1), req_we_i (1), req_addr_i (ADDR_WIDTH), req_data_i (DATA_WIDTH), req_sel_i (SEL_WIDTH) and req_tag_i (TAG_WIDTH), all inputs, carrying the transfer request.
REQ-011 SHALL have local response ports req_ready_o (1), rsp_valid_o (1), rsp_data_o (DATA_WIDTH) and rsp_status_o (2), all outputs.
REQ-012 SHALL have Wishbone outputs adr_o, dat_o, sel_o, tag_o, we_o, stb_o and cyc_o, each at its parameter width (1 where no parameter applies).
REQ-013 SHALL have Wishbone inputs dat_i (DATA_WIDTH) and ack_i, err_i and rty_i (1 each).

Function
REQ-014 SHALL implement the FSM states IDLE, ACTIVE and BACKOFF.
REQ-015 SHALL drive req_ready_o=1 only in IDLE; a request is accepted in the cycle where req_i=1 and req_ready_o=1.
REQ-016 On acceptance, SHALL register addr, data, sel, tag and we, clear the retry and timeout counters, and enter ACTIVE on the next cycle.
REQ-017 In ACTIVE, SHALL drive cyc_o=stb_o=1 with the registered fields, holding them stable until a termination occurs.
REQ-018 SHALL sample terminations only in ACTIVE, with priority err_i > ack_i > rty_i > timeout.
REQ-019 On ack_i, SHALL drop cyc_o and stb_o the next cycle, return to IDLE, and pulse rsp_valid_o for 1 cycle with rsp_data_o=dat_i (registered for reads; 0 for writes) and rsp_status_o=00.
REQ-020 On err_i, SHALL drop cyc_o and stb_o, go to IDLE, and pulse rsp_valid_o with status 01 and rsp_data_o=0.
REQ-021 On rty_i with retry_cnt<MAX_RETRY, SHALL increment retry_cnt and enter BACKOFF with cyc_o=stb_o=0, so the arbiter can re-arbitrate.
REQ-022 On rty_i with retry_cnt==MAX_RETRY, SHALL go to IDLE and pulse status 10; MAX_RETRY=0 terminates on the first rty_i.
REQ-023 In BACKOFF, SHALL count BACKOFF_CYCLES, then re-enter ACTIVE with identical fields and the timeout counter cleared.
REQ-024 Minimum latency SHALL be: accept at cycle N, cyc_o at N+1, ack_i at N+1, rsp_valid_o at N+2, req_ready_o at N+2.
REQ-025 A new request SHALL be acceptable in the same cycle that rsp_valid_o pulses.
REQ-026 Counters SHALL saturate and never wrap; the timeout counter SHALL be 16 bits and retry_cnt 8 bits.

Reset
REQ-027 On reset, all outputs SHALL be 0 except req_ready_o=1, the FSM SHALL be in IDLE, and the counters SHALL be 0.
REQ-028 A reset asserted mid-transfer SHALL drop cyc_o and stb_o asynchronously, discard the transfer, and issue no response.

Configuration
REQ-029 With macro WB_MASTER_TIMEOUT_EN defined, the port SHALL terminate ACTIVE after TIMEOUT_CYCLES cycles without a termination, with status 11; ack_i and err_i in that same cycle SHALL win.
REQ-030 Without WB_MASTER_TIMEOUT_EN, no timeout counter SHALL exist, ACTIVE SHALL wait indefinitely, and status 11 SHALL never occur.

Structure
REQ-031 SHALL place the status codes (OK=00, ERR=01, RETRY=10, TIMEOUT=11) and the FSM state encodings in the shared package wishbone_pkg.
REQ-032 SHALL use one sub-module, wb_sat_counter (a parameterised saturating counter with clear and enable), for the retry, backoff and timeout counters.

Verification
REQ-033 Read to addr 0x0000_0010 with ack_i in the first ACTIVE cycle, dat_i=0xDEADBEEF -> rsp_valid_o at N+2, rsp_data_o=0xDEADBEEF, status 00.
REQ-034 Write with 3 wait states, then err_i -> cyc_o high for exactly 4 cycles, status 01, rsp_data_o=0.
REQ-035 MAX_RETRY=2 with rty_i on every attempt -> 3 ACTIVE phases, each separated by 2 cycles of cyc_o=0, then status 10.
REQ-036 With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no termination -> status 11 after 8 ACTIVE cycles; a repeat with ack_i in the 8th cycle -> status 00.
REQ-037 Reset asserted in the 2nd ACTIVE cycle -> cyc_o=0 in the same cycle, no rsp_valid_o, req_ready_o=1; the next request completes normally.
